// File: rtl/mem_stage.sv
// Memory pipeline stage: data-bus access, address exception checks, load extension
// and the M/W pipeline register.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [31:0] EBase,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_Ins,
    input  logic        M_DS,
    input  logic [4:0]  temp_M_ExcCode,
    input  logic        M_Exc_DMOv,
    input  logic [31:0] M_ALU_Y,
    input  logic [31:0] M_rt_fw,
    input  logic [31:0] M_HI,
    input  logic [31:0] M_LO,
    input  logic [4:0]  M_GRF_WA,
    input  logic [2:0]  M_WDSrc,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [4:0]  M_ExcCode,
    output logic [31:0] M_GRF_WD,
    output logic [1:0]  M_Tnew,
    output logic [31:0] W_PC,
    output logic [31:0] W_Ins,
    output logic [4:0]  W_GRF_WA,
    output logic [31:0] W_GRF_WD
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    logic [5:0]  op;
    logic        is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
    logic        is_load, is_store;
    logic        in_dm, in_tc0, in_tc1, in_ig, in_map, in_timer, is_count;
    logic        misalign, load_bad, store_bad;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [31:0] load_data;

    logic [31:0] w_pc_q, w_pc_d;
    logic [31:0] w_ins_q, w_ins_d;
    logic [4:0]  w_wa_q, w_wa_d;
    logic [31:0] w_wd_q, w_wd_d;

    assign op       = M_Ins[31:26];
    assign is_lw    = (op == OP_LW);
    assign is_lh    = (op == OP_LH);
    assign is_lhu   = (op == OP_LHU);
    assign is_lb    = (op == OP_LB);
    assign is_lbu   = (op == OP_LBU);
    assign is_sw    = (op == OP_SW);
    assign is_sh    = (op == OP_SH);
    assign is_sb    = (op == OP_SB);
    assign is_load  = is_lw | is_lh | is_lhu | is_lb | is_lbu;
    assign is_store = is_sw | is_sh | is_sb;

    assign m_data_addr = M_ALU_Y;

    assign in_dm    = (M_ALU_Y <= 32'h0000_2FFF);
    assign in_tc0   = (M_ALU_Y >= 32'h0000_7F00) && (M_ALU_Y <= 32'h0000_7F0B);
    assign in_tc1   = (M_ALU_Y >= 32'h0000_7F10) && (M_ALU_Y <= 32'h0000_7F1B);
    assign in_ig    = (M_ALU_Y >= 32'h0000_7F20) && (M_ALU_Y <= 32'h0000_7F23);
    assign in_map   = in_dm | in_tc0 | in_tc1 | in_ig;
    assign in_timer = in_tc0 | in_tc1;
    // Timer count registers are read-only from the bus.
    assign is_count = (M_ALU_Y == 32'h0000_7F08) || (M_ALU_Y == 32'h0000_7F18);

    assign misalign = ((is_lw | is_sw) & (M_ALU_Y[1:0] != 2'b00)) |
                      ((is_lh | is_lhu | is_sh) & M_ALU_Y[0]);

    assign load_bad  = is_load & (misalign | M_Exc_DMOv | ~in_map |
                                  (~is_lw & in_timer));
    assign store_bad = is_store & (misalign | M_Exc_DMOv | ~in_map |
                                   (~is_sw & in_timer) | is_count);

    always_comb begin
        if (temp_M_ExcCode != 5'd0) M_ExcCode = temp_M_ExcCode;
        else if (load_bad)          M_ExcCode = 5'd4;
        else if (store_bad)         M_ExcCode = 5'd5;
        else                        M_ExcCode = 5'd0;
    end

    always_comb begin
        m_data_byteen = 4'b0000;
        m_data_wdata  = M_rt_fw;
        if (is_sh) m_data_wdata = {2{M_rt_fw[15:0]}};
        if (is_sb) m_data_wdata = {4{M_rt_fw[7:0]}};
        if (reset && !Req && M_ExcCode == 5'd0) begin
            if (is_sw)      m_data_byteen = 4'b1111;
            else if (is_sh) m_data_byteen = 4'b0011 << M_ALU_Y[1:0];
            else if (is_sb) m_data_byteen = 4'b0001 << M_ALU_Y[1:0];
        end
    end

    always_comb begin
        case (M_WDSrc)
            3'b001:  M_GRF_WD = 32'd0;
            3'b010:  M_GRF_WD = M_PC + 32'd8;
            3'b011:  M_GRF_WD = M_HI;
            3'b100:  M_GRF_WD = M_LO;
            default: M_GRF_WD = M_ALU_Y;
        endcase
    end

    assign M_Tnew = (M_WDSrc == 3'b001) ? 2'd1 : 2'd0;

    always_comb begin
        half = M_ALU_Y[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
        case (M_ALU_Y[1:0])
            2'b00:   byte_sel = m_data_rdata[7:0];
            2'b01:   byte_sel = m_data_rdata[15:8];
            2'b10:   byte_sel = m_data_rdata[23:16];
            default: byte_sel = m_data_rdata[31:24];
        endcase
        if (is_lh)       load_data = {{16{half[15]}}, half};
        else if (is_lhu) load_data = {16'd0, half};
        else if (is_lb)  load_data = {{24{byte_sel[7]}}, byte_sel};
        else if (is_lbu) load_data = {24'd0, byte_sel};
        else             load_data = m_data_rdata;
    end

    always_comb begin
        w_pc_d  = M_PC;
        w_ins_d = M_Ins;
        w_wa_d  = (M_ExcCode != 5'd0) ? 5'd0 : M_GRF_WA;
        w_wd_d  = is_load ? load_data : M_GRF_WD;
        if (Req) begin
            w_pc_d  = EBase;
            w_ins_d = 32'd0;
            w_wa_d  = 5'd0;
            w_wd_d  = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_pc_q  <= 32'd0;
            w_ins_q <= 32'd0;
            w_wa_q  <= 5'd0;
            w_wd_q  <= 32'd0;
        end else begin
            w_pc_q  <= w_pc_d;
            w_ins_q <= w_ins_d;
            w_wa_q  <= w_wa_d;
            w_wd_q  <= w_wd_d;
        end
    end

    assign W_PC     = w_pc_q;
    assign W_Ins    = w_ins_q;
    assign W_GRF_WA = w_wa_q;
    assign W_GRF_WD = w_wd_q;

    // The delay-slot flag is consumed by CP0 directly, not by this stage.
    logic unused_ds;
    assign unused_ds = M_DS;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors, a byte-level reference model checked every
// cycle, and literal expectations for the key scenarios.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset, Req, M_DS, M_Exc_DMOv;
    logic [31:0] EBase, M_PC, M_Ins, M_ALU_Y, M_rt_fw, M_HI, M_LO, m_data_rdata;
    logic [4:0]  temp_M_ExcCode, M_GRF_WA;
    logic [2:0]  M_WDSrc;
    logic [31:0] m_data_addr, m_data_wdata, M_GRF_WD, W_PC, W_Ins, W_GRF_WD;
    logic [3:0]  m_data_byteen;
    logic [4:0]  M_ExcCode, W_GRF_WA;
    logic [1:0]  M_Tnew;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .Req(Req), .EBase(EBase),
        .M_PC(M_PC), .M_Ins(M_Ins), .M_DS(M_DS), .temp_M_ExcCode(temp_M_ExcCode),
        .M_Exc_DMOv(M_Exc_DMOv), .M_ALU_Y(M_ALU_Y), .M_rt_fw(M_rt_fw),
        .M_HI(M_HI), .M_LO(M_LO), .M_GRF_WA(M_GRF_WA), .M_WDSrc(M_WDSrc),
        .m_data_rdata(m_data_rdata), .m_data_addr(m_data_addr),
        .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
        .M_ExcCode(M_ExcCode), .M_GRF_WD(M_GRF_WD), .M_Tnew(M_Tnew),
        .W_PC(W_PC), .W_Ins(W_Ins), .W_GRF_WA(W_GRF_WA), .W_GRF_WD(W_GRF_WD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  exc;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] gwd;
        logic [1:0]  tnew;
        logic        is_store;
        logic [31:0] w_pc, w_ins, w_wd;
        logic [4:0]  w_wa;
    } model_t;

    // Reference model expressed in terms of access size and byte offsets.
    function automatic model_t model();
        model_t m;
        int unsigned a, size, off, bits;
        bit ld, st, sgn, in_map, timer, bad;
        logic [31:0] v, mask;
        a = M_ALU_Y; ld = 0; st = 0; sgn = 0; size = 0;
        case (M_Ins[31:26])
            6'b100011: begin ld = 1; size = 4; end
            6'b100001: begin ld = 1; size = 2; sgn = 1; end
            6'b100101: begin ld = 1; size = 2; end
            6'b100000: begin ld = 1; size = 1; sgn = 1; end
            6'b100100: begin ld = 1; size = 1; end
            6'b101011: begin st = 1; size = 4; end
            6'b101001: begin st = 1; size = 2; end
            6'b101000: begin st = 1; size = 1; end
            default: ;
        endcase
        timer  = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
        in_map = (a <= 32'h2FFF) || timer || (a >= 32'h7F20 && a <= 32'h7F23);
        bad = 0;
        if (ld || st)
            bad = (a % size != 0) || M_Exc_DMOv || !in_map || (size < 4 && timer) ||
                  (st && (a == 32'h7F08 || a == 32'h7F18));
        if (temp_M_ExcCode != 0)  m.exc = temp_M_ExcCode;
        else if (ld && bad)       m.exc = 5'd4;
        else if (st && bad)       m.exc = 5'd5;
        else                      m.exc = 5'd0;
        m.is_store = st;
        m.be = 4'd0;
        if (st && m.exc == 0 && !Req && reset)
            m.be = 4'(((32'd1 << size) - 1) << (a % 4));
        m.wdata = M_rt_fw;
        if (st)
            for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = M_rt_fw[8*(i % size) +: 8];
        case (M_WDSrc)
            3'd1:    m.gwd = 0;
            3'd2:    m.gwd = M_PC + 8;
            3'd3:    m.gwd = M_HI;
            3'd4:    m.gwd = M_LO;
            default: m.gwd = M_ALU_Y;
        endcase
        m.tnew = (M_WDSrc == 3'd1) ? 2'd1 : 2'd0;
        v = m.gwd;
        if (ld) begin
            off  = (a % 4) - ((a % 4) % size);
            bits = 8 * size;
            v    = m_data_rdata >> (8 * off);
            if (size < 4) begin
                mask = (32'd1 << bits) - 1;
                v = v & mask;
                if (sgn && v[bits-1]) v = v | ~mask;
            end
        end
        m.w_pc = M_PC; m.w_ins = M_Ins; m.w_wd = v;
        m.w_wa = (m.exc != 0) ? 5'd0 : M_GRF_WA;
        if (Req) begin m.w_pc = EBase; m.w_ins = 0; m.w_wa = 0; m.w_wd = 0; end
        if (!reset) begin m.w_pc = 0; m.w_ins = 0; m.w_wa = 0; m.w_wd = 0; end
        return m;
    endfunction

    model_t exp_w;
    bit     w_valid = 0;

    always @(negedge clk) begin
        model_t m;
        if (w_valid) begin
            chk("m_W_PC", W_PC, exp_w.w_pc);
            chk("m_W_Ins", W_Ins, exp_w.w_ins);
            chk("m_W_GRF_WA", {27'd0, W_GRF_WA}, {27'd0, exp_w.w_wa});
            chk("m_W_GRF_WD", W_GRF_WD, exp_w.w_wd);
        end
        m = model();
        chk("m_addr", m_data_addr, M_ALU_Y);
        chk("m_ExcCode", {27'd0, M_ExcCode}, {27'd0, m.exc});
        chk("m_byteen", {28'd0, m_data_byteen}, {28'd0, m.be});
        if (m.is_store) chk("m_wdata", m_data_wdata, m.wdata);
        chk("m_GRF_WD", M_GRF_WD, m.gwd);
        chk("m_Tnew", {30'd0, M_Tnew}, {30'd0, m.tnew});
        exp_w   = m;
        w_valid = 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] rdata, input logic [2:0] src, input logic [4:0] wa,
                         input logic dmov, input logic [4:0] tc);
        M_PC           = M_PC + 32'd4;
        M_Ins          = {op, 26'h0155AA3};
        M_ALU_Y        = addr;
        M_rt_fw        = rt;
        m_data_rdata   = rdata;
        M_WDSrc        = src;
        M_GRF_WA       = wa;
        M_Exc_DMOv     = dmov;
        temp_M_ExcCode = tc;
    endtask

    initial begin
        reset = 0; Req = 0; M_DS = 0; EBase = 32'h0000_4180;
        M_PC = 32'h0000_3000; M_Ins = 0; M_ALU_Y = 0; M_rt_fw = 0;
        M_HI = 32'hAAAA_0001; M_LO = 32'h5555_0002; m_data_rdata = 0;
        M_GRF_WA = 0; M_WDSrc = 0; M_Exc_DMOv = 0; temp_M_ExcCode = 0;

        // Store held during reset must not reach the bus.
        drive(6'b101011, 32'h10, 32'hDEAD_BEEF, 0, 3'd0, 5'd3, 0, 0);
        #1 chk("rst_byteen", {28'd0, m_data_byteen}, 32'd0);
        step(); step();
        chk("rst_W_PC", W_PC, 32'd0);
        chk("rst_W_WA", {27'd0, W_GRF_WA}, 32'd0);
        reset = 1;

        drive(6'b101000, 32'h0000_1003, 32'h1234_56AB, 0, 3'd0, 5'd0, 0, 0);
        #1;
        chk("sb_byteen", {28'd0, m_data_byteen}, 32'h8);
        chk("sb_wdata", m_data_wdata, 32'hABAB_ABAB);
        chk("sb_exc", {27'd0, M_ExcCode}, 32'd0);
        step();

        drive(6'b100001, 32'h0000_0002, 0, 32'h8001_7FFF, 3'd1, 5'd9, 0, 0);
        #1;
        chk("lh_tnew", {30'd0, M_Tnew}, 32'd1);
        chk("lh_gwd", M_GRF_WD, 32'd0);
        step();
        chk("lh_W_WD", W_GRF_WD, 32'hFFFF_8001);
        chk("lh_W_WA", {27'd0, W_GRF_WA}, 32'd9);

        drive(6'b101011, 32'h0000_7F08, 32'h1, 0, 3'd0, 5'd7, 0, 0);
        #1;
        chk("swcnt_exc", {27'd0, M_ExcCode}, 32'd5);
        chk("swcnt_byteen", {28'd0, m_data_byteen}, 32'd0);
        step();
        chk("swcnt_W_WA", {27'd0, W_GRF_WA}, 32'd0);

        drive(6'b100011, 32'h0000_3000, 0, 32'h1, 3'd1, 5'd4, 0, 0);
        #1 chk("lw_oob_exc", {27'd0, M_ExcCode}, 32'd4);
        step();
        drive(6'b100011, 32'h0000_3000, 0, 32'h1, 3'd1, 5'd4, 0, 5'd12);
        #1 chk("lw_prio_exc", {27'd0, M_ExcCode}, 32'd12);
        step();

        // Further directed vectors checked by the model.
        drive(6'b100100, 32'h0000_0011, 0, 32'h1122_83F4, 3'd1, 5'd2, 0, 0); step(); // lbu
        drive(6'b100000, 32'h0000_0011, 0, 32'h1122_83F4, 3'd1, 5'd2, 0, 0); step(); // lb
        drive(6'b100101, 32'h0000_0002, 0, 32'h8001_7FFF, 3'd1, 5'd5, 0, 0); step(); // lhu
        drive(6'b100011, 32'h0000_7F0B, 0, 32'h0, 3'd1, 5'd5, 0, 0); step();          // lw misaligned timer
        drive(6'b100011, 32'h0000_7F04, 0, 32'hCAFE_F00D, 3'd1, 5'd6, 0, 0); step();  // lw timer ok
        drive(6'b100000, 32'h0000_7F14, 0, 32'h0, 3'd1, 5'd6, 0, 0); step();          // lb timer bad
        drive(6'b100011, 32'h0000_2FFC, 0, 32'h1357_9BDF, 3'd1, 5'd8, 0, 0); step();  // lw top of DM
        drive(6'b100011, 32'h0000_0100, 0, 32'h0, 3'd1, 5'd8, 1, 0); step();          // DMOv
        drive(6'b101001, 32'h0000_0006, 32'hFFFF_BEEF, 0, 3'd0, 5'd0, 0, 0); step();  // sh upper half
        drive(6'b101001, 32'h0000_0005, 32'hFFFF_BEEF, 0, 3'd0, 5'd0, 0, 0); step();  // sh misaligned
        drive(6'b101000, 32'h0000_7F23, 32'h0000_0077, 0, 3'd0, 5'd0, 0, 0); step();  // sb IG end
        drive(6'b101000, 32'h0000_7F00, 32'h0000_0077, 0, 3'd0, 5'd0, 0, 0); step();  // sb timer bad
        drive(6'b101011, 32'h0000_7F10, 32'h0000_0009, 0, 3'd0, 5'd0, 0, 0); step();  // sw timer ctrl
        drive(6'b101011, 32'h0000_7F18, 32'h0000_0009, 0, 3'd0, 5'd0, 0, 0); step();  // sw TC1 count
        drive(6'b000000, 32'h0000_1234, 0, 0, 3'd2, 5'd31, 0, 0); step();             // PC+8
        drive(6'b000000, 32'h0000_1234, 0, 0, 3'd3, 5'd30, 0, 0); step();             // HI
        drive(6'b000000, 32'h0000_1234, 0, 0, 3'd4, 5'd29, 0, 0); step();             // LO
        drive(6'b000000, 32'h0000_1234, 0, 0, 3'd7, 5'd28, 0, 3'd0); step();          // default ALU

        drive(6'b101011, 32'h0000_0020, 32'h1111_2222, 0, 3'd0, 5'd3, 0, 0);
        Req = 1;
        #1 chk("req_byteen", {28'd0, m_data_byteen}, 32'd0);
        step();
        chk("req_W_PC", W_PC, 32'h0000_4180);
        chk("req_W_Ins", W_Ins, 32'd0);
        chk("req_W_WA", {27'd0, W_GRF_WA}, 32'd0);

        drive(6'b100011, 32'h0000_0040, 0, 32'h5, 3'd1, 5'd3, 0, 0);
        reset = 0;
        step();
        chk("rstreq_W_PC", W_PC, 32'd0);
        chk("rstreq_W_WD", W_GRF_WD, 32'd0);
        reset = 1; Req = 0;
        drive(6'b100011, 32'h0000_0040, 0, 32'h5, 3'd1, 5'd3, 0, 0);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets.
- Req  in  1  CP0 exception/eret flush request.
- EBase  in  32  handler PC loaded on flush.
- M_PC, M_Ins  in  32 each  M-stage instruction.
- M_DS  in  1  delay-slot flag.
- temp_M_ExcCode  in  5  exception code carried from earlier stages.
- M_Exc_DMOv  in  1  address-add overflow flagged by E.
- M_ALU_Y  in  32  ALU result / effective address.
- M_rt_fw  in  32  forwarded store data.
- M_HI, M_LO  in  32 each  MDU results.
- M_GRF_WA  in  5  destination register (0 = none).
- M_WDSrc  in  3  write-data select: 000 ALU, 001 DM, 010 PC+8, 011 HI, 100 LO, other ALU.
- m_data_rdata  in  32  bus read word, valid in the same cycle as the address.
- m_data_addr  out  32  bus address.
- m_data_wdata  out  32  bus write data.
- m_data_byteen  out  4  bus byte enables.
- M_ExcCode  out  5  final M-stage exception code, to CP0.
- M_GRF_WD  out  32  M-stage forwarding value.
- M_Tnew  out  2  cycles until the result is ready.
- W_PC, W_Ins  out  32 each  W-stage registers.
- W_GRF_WA  out  5  W-stage destination.
- W_GRF_WD  out  32  W-stage write-back data.

Function
REQ-002 Loads/stores SHALL be decoded from M_Ins[31:26]:
- lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100
- sw 101011, sh 101001, sb 101000
REQ-003 m_data_addr SHALL equal M_ALU_Y.
REQ-004 Store byte enables and write data SHALL be:
- sw: byteen 1111, wdata = rt.
- sh: byteen 0011 << addr[1:0], wdata = rt[15:0] replicated ×2.
- sb: byteen 0001 << addr[1:0], wdata = rt[7:0] replicated ×4.
- non-store: byteen 0000.
REQ-005 The valid map SHALL be: DM 0x0000–0x2FFF, TC0 0x7F00–0x7F0B, TC1 0x7F10–0x7F1B, IG 0x7F20–0x7F23.
REQ-006 A load SHALL raise AdEL (5'd4) when any of the following holds:
- misaligned (lw addr[1:0]≠0; lh/lhu addr[0]≠0);
- M_Exc_DMOv;
- address outside the map;
- lh/lhu/lb/lbu to TC0/TC1.
REQ-007 A store SHALL raise AdES (5'd5) when any of the following holds:
- misaligned;
- M_Exc_DMOv;
- outside the map;
- sh/sb to a timer;
- address TC0/TC1 base+8 (count register).
REQ-008 M_ExcCode priority SHALL be: temp_M_ExcCode if nonzero, else AdEL/AdES, else 0.
REQ-009 m_data_byteen SHALL be 0000 whenever M_ExcCode≠0 or Req=1.
REQ-010 M_GRF_WD SHALL be selected by M_WDSrc: PC+8, HI, LO, else M_ALU_Y; it is 0 when WDSrc=001.
REQ-011 M_Tnew SHALL be 1 for WDSrc=001, else 0.
REQ-012 The W register SHALL update every edge (no stall) from the M_ inputs.
REQ-013 W_GRF_WD SHALL capture M_GRF_WD, except for loads, where it captures the load-extended m_data_rdata:
- lw: whole word.
- lh/lhu: halfword at addr[1], sign/zero extended.
- lb/lbu: byte at addr[1:0], sign/zero extended.
REQ-014 W_GRF_WA SHALL capture 0 when M_ExcCode≠0, so a faulting instruction never writes back.
REQ-015 Req=1 (reset high) SHALL load W_PC←EBase and all other W registers ←0.
REQ-016 When reset=0 and Req=1 in the same cycle, reset SHALL take precedence.

Reset
REQ-017 reset=0 at an edge SHALL clear W_PC, W_Ins, W_GRF_WA and W_GRF_WD to 0.
REQ-018 While reset=0, the block SHALL drive m_data_byteen=0000.
REQ-019 Combinational outputs SHALL follow their inputs during reset, with no internal state beyond the W register.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- sb, addr 0x0000_1003, rt 0x1234_56AB → byteen 1000, wdata 0xABABABAB, ExcCode 0.
- lh, addr 0x0000_0002, rdata 0x8001_7FFF → next cycle W_GRF_WD 0xFFFF8001, W_GRF_WA = M_GRF_WA.
- sw to 0x7F08 → M_ExcCode 5, byteen 0000, next W_GRF_WA 0.
- lw addr 0x3000 → ExcCode 4; lw with temp_M_ExcCode=12 → ExcCode 12 (priority).
- Req=1, EBase 0x4180 → next W_PC 0x4180, W_Ins 0, byteen 0000 during the Req cycle.
- reset=0 together with Req=1 → next W_PC 0, all W registers 0.
